// File: rtl/vc_arbiter_if.sv
// Handshake bundle between the VC arbiter, its four source FIFOs and the
// four destination FIFOs; the arbiter takes the slave side.
interface vc_arbiter_if #(
  parameter int DATA_WIDTH = 6
);
  logic                    enable;
  logic [3:0]              fifos_empty;
  logic [4*DATA_WIDTH-1:0] fifos_data;
  logic [3:0]              dest_almost_full;
  logic [3:0]              pop;
  logic [3:0]              push;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    idle;

  modport slave (
    input  enable, fifos_empty, fifos_data, dest_almost_full,
    output pop, push, data_out, idle
  );

  modport master (
    output enable, fifos_empty, fifos_data, dest_almost_full,
    input  pop, push, data_out, idle
  );
endinterface

// File: rtl/vc_arbiter.sv
// Round-robin drain of four virtual-channel FIFOs into four destination FIFOs.
// Pipeline: grant/pop (p0), source capture (p1), routed push of the word (p2).
module vc_arbiter #(
  parameter int DATA_WIDTH = 6
) (
  input  logic        clk,
  input  logic        reset_L,
  vc_arbiter_if.slave vc
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_PAUSE  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [1:0]            rr_q, rr_d;
  logic [3:0]            pop_p0_q, pop_p0_d;
  logic [1:0]            src_p0_q;
  logic                  vld_p1_q;
  logic [1:0]            src_p1_q;
  logic [3:0]            push_p2_q, push_p2_d;
  logic [DATA_WIDTH-1:0] data_p2_q, data_p2_d;
  logic                  idle_q, idle_d;

  logic                  any_af;
  logic [3:0]            elig;
  logic                  grant_vld;
  logic [1:0]            grant_idx;
  logic [1:0]            cand;
  logic [DATA_WIDTH-1:0] src_word [4];
  logic [DATA_WIDTH-1:0] word_p1;
  logic [1:0]            dest_p1;

  // Stage 0: grant decision. A source popped at the last edge still shows a
  // stale empty flag, so it sits out one cycle.
  assign any_af = |vc.dest_almost_full;
  assign elig   = (state_q == ST_ACTIVE && vc.enable && !any_af) ?
                  (~vc.fifos_empty & ~pop_p0_q) : 4'b0000;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_q;
    cand      = rr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_q + 2'(k);
      if (elig[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign pop_p0_d = grant_vld ? (4'b0001 << grant_idx) : 4'b0000;
  assign rr_d     = grant_vld ? (grant_idx + 2'd1) : rr_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (vc.enable) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (!vc.enable)  state_d = ST_IDLE;
        else if (any_af) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (!vc.enable)   state_d = ST_IDLE;
        else if (!any_af) state_d = ST_ACTIVE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Stage 2: the popped word is on its source lane now; route it by its top bits.
  for (genvar i = 0; i < 4; i++) begin : g_word
    assign src_word[i] = vc.fifos_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign word_p1   = src_word[src_p1_q];
  assign dest_p1   = word_p1[DATA_WIDTH-1 -: 2];
  assign push_p2_d = vld_p1_q ? (4'b0001 << dest_p1) : 4'b0000;
  assign data_p2_d = vld_p1_q ? word_p1 : data_p2_q;

  // Idle looks ahead so it agrees with the state and valids registered alongside it.
  assign idle_d = (state_d == ST_IDLE) && (pop_p0_q == 4'b0000) && !vld_p1_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= ST_IDLE;
      rr_q      <= 2'd0;
      pop_p0_q  <= 4'b0000;
      src_p0_q  <= 2'd0;
      vld_p1_q  <= 1'b0;
      src_p1_q  <= 2'd0;
      push_p2_q <= 4'b0000;
      data_p2_q <= '0;
      idle_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      pop_p0_q  <= pop_p0_d;
      src_p0_q  <= grant_idx;
      // Stage 1: remember which lane the word will appear on.
      vld_p1_q  <= |pop_p0_q;
      src_p1_q  <= src_p0_q;
      push_p2_q <= push_p2_d;
      data_p2_q <= data_p2_d;
      idle_q    <= idle_d;
    end
  end

  assign vc.pop      = pop_p0_q;
  assign vc.push     = push_p2_q;
  assign vc.data_out = data_p2_q;
  assign vc.idle     = idle_q;

endmodule

// File: tb/tb_vc_arbiter.sv
// Bench for vc_arbiter: mock source FIFOs plus a delivery-schedule model of
// the arbiter, compared on every falling edge, and a few pinned literal cases.
module tb_vc_arbiter;
  localparam int DW      = 6;
  localparam int M_IDLE  = 0;
  localparam int M_ACT   = 1;
  localparam int M_PAUSE = 2;

  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  vc_arbiter_if #(.DATA_WIDTH(DW)) vif ();
  vc_arbiter #(.DATA_WIDTH(DW)) dut (.clk(clk), .reset_L(reset_L), .vc(vif));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [DW-1:0] mem [4][256];
  int            head [4];
  int            tail [4];
  logic [DW-1:0] rd [4];
  logic [3:0]    prev_pop;
  logic          en;
  logic [3:0]    af;

  int            mode, rr, last_g;
  bit            sched_v [4];
  logic [DW-1:0] sched_w [4];
  logic [3:0]    exp_pop, exp_push;
  logic [DW-1:0] exp_data;
  logic          exp_idle;

  logic [3:0]    obs_pop  [4096];
  logic [3:0]    obs_push [4096];
  logic [DW-1:0] obs_data [4096];
  logic          obs_idle [4096];

  function automatic int fsize(int i);
    return tail[i] - head[i];
  endfunction

  task automatic fpush(int i, logic [DW-1:0] w);
    if (fsize(i) < 8) begin
      mem[i][tail[i] % 256] = w;
      tail[i]++;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  // Source FIFOs react to the pop they sampled, inputs are driven, then the
  // model predicts what the next edge must produce.
  task automatic prep();
    int g;
    int idx;
    logic [DW-1:0] w;
    for (int i = 0; i < 4; i++)
      if (prev_pop[i] && fsize(i) > 0) begin
        rd[i] = mem[i][head[i] % 256];
        head[i]++;
      end
    prev_pop = vif.pop;
    for (int i = 0; i < 4; i++) begin
      vif.fifos_empty[i]         = (fsize(i) == 0);
      vif.fifos_data[i*DW +: DW] = rd[i];
    end
    vif.enable           = en;
    vif.dest_almost_full = af;

    g = -1;
    if (mode == M_ACT && en && af == 4'b0000)
      for (int o = 0; o < 4; o++) begin
        idx = (rr + o) % 4;
        if (g < 0 && fsize(idx) > 0 && idx != last_g) g = idx;
      end
    case (mode)
      M_IDLE:  if (en) mode = M_ACT;
      M_ACT:   if (!en) mode = M_IDLE; else if (af != 4'b0000) mode = M_PAUSE;
      M_PAUSE: if (!en) mode = M_IDLE; else if (af == 4'b0000) mode = M_ACT;
      default: mode = M_IDLE;
    endcase

    exp_pop = (g >= 0) ? 4'(1 << g) : 4'b0000;
    sched_v[(cyc + 3) % 4] = (g >= 0);
    if (g >= 0) begin
      sched_w[(cyc + 3) % 4] = mem[g][head[g] % 256];
      rr = (g + 1) % 4;
    end
    last_g = g;

    if (sched_v[(cyc + 1) % 4]) begin
      w        = sched_w[(cyc + 1) % 4];
      exp_push = 4'(1 << w[DW-1 -: 2]);
      exp_data = w;
    end else begin
      exp_push = 4'b0000;
    end
    exp_idle = (mode == M_IDLE) && !sched_v[(cyc + 1) % 4] && !sched_v[(cyc + 2) % 4];
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    obs_pop[cyc % 4096]  = vif.pop;
    obs_push[cyc % 4096] = vif.push;
    obs_data[cyc % 4096] = vif.data_out;
    obs_idle[cyc % 4096] = vif.idle;
    chk("pop",      32'(vif.pop),      32'(exp_pop));
    chk("push",     32'(vif.push),     32'(exp_push));
    chk("data_out", 32'(vif.data_out), 32'(exp_data));
    chk("idle",     32'(vif.idle),     32'(exp_idle));
    prep();
  endtask

  task automatic reset_mid();
    #2 reset_L = 1'b0;
    #1;
    chk("rst_pop",  32'(vif.pop),      32'h0);
    chk("rst_push", 32'(vif.push),     32'h0);
    chk("rst_data", 32'(vif.data_out), 32'h0);
    chk("rst_idle", 32'(vif.idle),     32'h1);
    en = 1'b0;
    repeat (2) @(negedge clk);
    reset_L  = 1'b1;
    mode     = M_IDLE;
    rr       = 0;
    last_g   = -1;
    prev_pop = 4'b0000;
    exp_data = '0;
    for (int i = 0; i < 4; i++) sched_v[i] = 1'b0;
    prep();
  endtask

  function automatic int count_nz_push(int from, int to);
    int n = 0;
    for (int c = from; c <= to; c++) if (obs_push[c % 4096] != 4'b0000) n++;
    return n;
  endfunction

  function automatic int count_nz_pop(int from, int to);
    int n = 0;
    for (int c = from; c <= to; c++) if (obs_pop[c % 4096] != 4'b0000) n++;
    return n;
  endfunction

  initial begin
    int c0, cs, b, d, c1, n, n2;
    bit found;
    logic [3:0] rr_exp [5];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    reset_L = 1'b1;
    en = 1'b0;
    af = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      tail[i] = 0;
      rd[i]   = '0;
    end
    vif.enable           = 1'b0;
    vif.fifos_empty      = 4'hF;
    vif.fifos_data       = '0;
    vif.dest_almost_full = 4'b0000;
    @(negedge clk);
    reset_mid();

    // Round-robin over four full sources; source 0 leads with a word for dest 2.
    fpush(0, 6'b100101);
    fpush(0, 6'($urandom));
    fpush(0, 6'($urandom));
    for (int i = 1; i < 4; i++) repeat (3) fpush(i, 6'($urandom));
    en = 1'b1;
    cycle();
    c0 = cyc;
    repeat (20) cycle();
    chk("startup_nopop", 32'(obs_pop[(c0 + 1) % 4096]), 32'h0);
    chk("startup_pop",   32'(obs_pop[(c0 + 2) % 4096]), 32'h1);
    n = 0;
    for (int c = c0 + 1; c <= c0 + 20; c++)
      if (obs_pop[c % 4096] != 4'b0000 && n < 5) begin
        chk($sformatf("rr_seq%0d", n), 32'(obs_pop[c % 4096]), 32'(rr_exp[n]));
        n++;
      end
    chk("rr_count",   32'(n), 32'd5);
    chk("route_push", 32'(obs_push[(c0 + 4) % 4096]), 32'h4);
    chk("route_data", 32'(obs_data[(c0 + 4) % 4096]), 32'h25);

    // Single source with three words: alternate-cycle pops.
    repeat (3) fpush(2, 6'($urandom));
    cs = cyc;
    repeat (16) cycle();
    n = 0;
    for (int c = cs + 1; c <= cs + 16; c++) if (obs_pop[c % 4096] == 4'b0100) n++;
    chk("single_pops_src2", 32'(n), 32'd3);
    chk("single_pops_all",  32'(count_nz_pop(cs + 1, cs + 16)), 32'd3);
    chk("single_pushes",    32'(count_nz_push(cs + 1, cs + 16)), 32'd3);

    // Backpressure on destination 1 while streaming.
    for (int i = 0; i < 4; i++) repeat (4) fpush(i, 6'($urandom));
    repeat (3) cycle();
    af = 4'b0010;
    cycle();
    b = cyc;
    repeat (5) cycle();
    chk("bp_no_pops",   32'(count_nz_pop(b + 1, b + 5)), 32'd0);
    chk("bp_push_le_2", 32'(count_nz_push(b + 1, b + 5) <= 2), 32'd1);
    af = 4'b0000;
    repeat (20) cycle();

    // Enable drop with two words in flight.
    for (int i = 0; i < 4; i++) repeat (4) fpush(i, 6'($urandom));
    repeat (4) cycle();
    en = 1'b0;
    cycle();
    d = cyc;
    repeat (8) cycle();
    chk("drop_pushes", 32'(count_nz_push(d + 1, d + 8)), 32'd2);
    chk("drop_idle_lo", 32'(obs_idle[(d + 2) % 4096]), 32'h0);
    chk("drop_idle_hi", 32'(obs_idle[(d + 3) % 4096]), 32'h1);

    // Reset while pop=0010 is out and a word is in flight.
    en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (vif.pop == 4'b0010) found = 1'b1;
    end
    chk("wait_pop0010", 32'(found), 32'h1);
    reset_mid();
    cs = cyc;
    repeat (5) cycle();
    chk("rst_discard", 32'(count_nz_push(cs + 1, cs + 5)), 32'd0);
    fpush(0, 6'($urandom));
    fpush(1, 6'($urandom));
    en = 1'b1;
    cycle();
    c1 = cyc;
    repeat (3) cycle();
    chk("rst_rr_zero", 32'(obs_pop[(c1 + 2) % 4096]), 32'h1);

    // Randomized traffic.
    repeat (800) begin
      en = ($urandom_range(0, 15) != 0);
      af = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      if ($urandom_range(0, 1) == 1) fpush(int'($urandom_range(0, 3)), 6'($urandom));
      if ($urandom_range(0, 3) == 0) fpush(int'($urandom_range(0, 3)), 6'($urandom));
      cycle();
    end
    en = 1'b1;
    af = 4'b0000;
    repeat (30) cycle();
    n2 = 0;
    for (int i = 0; i < 4; i++) n2 += fsize(i);
    chk("drained", 32'(n2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
